pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards,
//  branch/jump redirects, memory wait states and multi-cycle mul/div in EX.
//  Drives hold/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, including
//  id_shouldStall and ex_shouldJumpOrBranch-based flushing of IF/ID.
// PARAMETERS
//  MD_CYCLES    32   EX occupancy of a mul/div op, in cycles (>=2)
//  MD_CNT_W     6    counter width; must satisfy 2**MD_CNT_W > MD_CYCLES
//  MEM_TIMEOUT  255  max MEM_WAIT cycles before mem_timeout is set (>=1)
// PORTS
//  clk                    in   1  rising-edge clock
//  rst_n                  in   1  asynchronous, active-low reset
//  cpu_en                 in   1  global enable; 0 = freeze everything
//  id_rs, id_rt           in   5  source registers of instruction in ID
//  id_uses_rs, id_uses_rt in   1  ID instruction reads rs / rt
//  ex_mem_read            in   1  instruction in EX is a load
//  ex_rd                  in   5  destination register of instruction in EX
//  ex_shouldJumpOrBranch  in   1  redirect resolved in EX
//  ex_md_start            in   1  mul/div op entering execution in EX
//  mem_req                in   1  MEM stage access active
//  mem_ready              in   1  memory completes access this cycle
//  pc_hold                out  1  PC keeps value
//  id_shouldStall         out  1  IF/ID holds
//  ifid_flush             out  1  IF/ID loads bubble (0)
//  idex_flush             out  1  ID/EX loads bubble
//  ex_hold                out  1  ID/EX and EX/MEM hold
//  mem_bubble             out  1  EX/MEM loads bubble
//  wb_bubble              out  1  MEM/WB loads bubble
//  md_done                out  1  1-cycle pulse, mul/div result valid
//  mem_timeout            out  1  sticky error flag
//  ctrl_state             out  2  0 RUN, 1 MEM_WAIT, 2 MD_BUSY
// BEHAVIOUR
//  - Reset (async, rst_n=0): state RUN, md counter 0, timeout counter 0,
//    mem_timeout 0, md_done 0; all control outputs 0.
//  - Control outputs are combinational from state + inputs; state, counters,
//    md_done, and mem_timeout are registered.
//  - cpu_en=0: state and counters hold; md_done=0; pc_hold=id_shouldStall=ex_hold=1;
//    flush/bubble outputs 0.
//  - RUN priority (highest first):
//    1. mem_req & !mem_ready:
//       set pc_hold, id_shouldStall, ex_hold, wb_bubble; next MEM_WAIT.
//    2. ex_md_start:
//       set pc_hold, id_shouldStall, ex_hold, mem_bubble; load cnt=MD_CYCLES-1;
//       next MD_BUSY.
//    3. ex_shouldJumpOrBranch: ifid_flush=1, idex_flush=1, no hold.
//       Any simultaneous load-use is ignored because the instruction is flushed.
//    4. load-use, when ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) |
//       (id_uses_rt & id_rt==ex_rd)):
//       set pc_hold, id_shouldStall, idex_flush for exactly 1 cycle.
//  - MEM_WAIT: same holds as entry.
//    mem_ready=1 -> release holds that cycle (wb_bubble=0), next RUN, tcnt=0.
//    Otherwise tcnt++; when tcnt reaches MEM_TIMEOUT, set mem_timeout and keep
//    waiting. mem_timeout stays set until reset.
//  - MD_BUSY: holds as entry. cnt-- each enabled cycle.
//    At cnt==1, next RUN and md_done=1 on the RUN cycle.
//    Total EX occupancy is MD_CYCLES. Redirect and load-use are not evaluated.
//  - ex_rd==0 never causes a stall. Counters saturate and never wrap.
// TESTING
//  - ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle of
//    pc_hold=id_shouldStall=idex_flush=1; next cycle all 0.
//  - Same hazard + ex_shouldJumpOrBranch=1 -> ifid_flush=idex_flush=1,
//    pc_hold=0, id_shouldStall=0.
//  - mem_req=1, mem_ready low 3 cycles -> ctrl_state=1 for 3 cycles with
//    holds + wb_bubble; mem_ready=1 -> RUN, holds drop.
//  - MD_CYCLES=4, ex_md_start pulse -> MD_BUSY 3 cycles, then RUN with md_done
//    pulse; cpu_en=0 for 2 mid cycles extends the total by exactly 2.
//  - MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4 wait cycles;
//    mem_timeout stays 1 after mem_ready.
//  - rst_n low mid MD_BUSY (between clock edges) -> ctrl_state=0 and all
//    outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, redirect, memory wait and mul/div hazards
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES   = 32,
  parameter int MD_CNT_W    = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_en,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_shouldJumpOrBranch,
  input  logic       ex_md_start,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_hold,
  output logic       id_shouldStall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       ex_hold,
  output logic       mem_bubble,
  output logic       wb_bubble,
  output logic       md_done,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MD_BUSY = 2'd2} state_t;
  state_t state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tout_q, tout_d, done_q, done_d, lu_q, lu_d;
  logic mem_stall, load_use;
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
      done_q  <= 1'b0;
      lu_q    <= 1'b0;
    end else if (cpu_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
      done_q  <= done_d;
      lu_q    <= lu_d;
    end
  // lu_q limits a load-use stall to a single cycle even if ID/EX inputs linger
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    tout_d  = tout_q;
    done_d  = 1'b0;
    lu_d    = 1'b0;
    case (state_q)
      RUN:
        if (mem_stall) state_d = MEM_WAIT;
        else if (ex_md_start) begin
          state_d = MD_BUSY;
          cnt_d   = MD_CNT_W'(MD_CYCLES - 1);
        end else lu_d = ~ex_shouldJumpOrBranch & load_use & ~lu_q;
      MEM_WAIT:
        if (mem_ready) begin
          state_d = RUN;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(tcnt_q != TW'(MEM_TIMEOUT));
          tout_d = tout_q | (tcnt_d == TW'(MEM_TIMEOUT));
        end
      MD_BUSY: begin
        cnt_d = cnt_q - MD_CNT_W'(cnt_q != '0);
        if (cnt_q <= MD_CNT_W'(1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_comb begin
    pc_hold        = 1'b0;
    id_shouldStall = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    ex_hold        = 1'b0;
    mem_bubble     = 1'b0;
    wb_bubble      = 1'b0;
    if (!rst_n) begin
    end else if (!cpu_en) begin
      pc_hold        = 1'b1;
      id_shouldStall = 1'b1;
      ex_hold        = 1'b1;
    end else
      case (state_q)
        RUN:
          if (mem_stall) {pc_hold, id_shouldStall, ex_hold, wb_bubble} = 4'hf;
          else if (ex_md_start) {pc_hold, id_shouldStall, ex_hold, mem_bubble} = 4'hf;
          else if (ex_shouldJumpOrBranch) {ifid_flush, idex_flush} = 2'b11;
          else if (lu_d) {pc_hold, id_shouldStall, idex_flush} = 3'b111;
        MEM_WAIT: if (!mem_ready) {pc_hold, id_shouldStall, ex_hold, wb_bubble} = 4'hf;
        MD_BUSY: {pc_hold, id_shouldStall, ex_hold, mem_bubble} = 4'hf;
        default: ;
      endcase
  end
  assign md_done     = done_q & cpu_en & rst_n;
  assign mem_timeout = tout_q;
  assign ctrl_state  = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stalls, flushes, wait states and mul/div sequencing
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cpu_en = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0, br = 0, md_start = 0, mem_req = 0, mem_ready = 0;
  logic pc_hold, id_shouldStall, ifid_flush, idex_flush, ex_hold, mem_bubble, wb_bubble, md_done, mem_timeout;
  logic [1:0] st;
  logic [8:0] ctl;
  int errors = 0, checks = 0;
  // bit order: pc_hold, id_shouldStall, ifid_flush, idex_flush, ex_hold, mem_bubble, wb_bubble, md_done, mem_timeout
  localparam logic [8:0] NONE = 9'b000000000, STALL = 9'b110100000, BRANCH = 9'b001100000;
  localparam logic [8:0] MEMH = 9'b110010100, MDH = 9'b110011000, FRZ = 9'b110010000;
  localparam logic [8:0] DONE = 9'b000000010, TOUT = 9'b000000001;
  assign ctl = {pc_hold, id_shouldStall, ifid_flush, idex_flush, ex_hold, mem_bubble, wb_bubble, md_done, mem_timeout};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MD_CYCLES(4), .MD_CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_shouldJumpOrBranch(br), .ex_md_start(md_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .id_shouldStall(id_shouldStall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .ex_hold(ex_hold), .mem_bubble(mem_bubble), .wb_bubble(wb_bubble), .md_done(md_done),
    .mem_timeout(mem_timeout), .ctrl_state(st));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    {id_uses_rs, id_uses_rt, ex_mem_read, br, md_start, mem_req, mem_ready} = '0;
    id_rs = '0; id_rt = '0; ex_rd = '0;
  endtask
  task automatic test_reset;
    clear_in();
    #1;
    checks++; if (ctl !== NONE || st !== 2'd0) begin errors++; $display("FAIL reset_low ctl=%b st=%0d exp ctl=%b st=0", ctl, st, NONE); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ctl !== NONE || st !== 2'd0) begin errors++; $display("FAIL reset_rel ctl=%b st=%0d exp ctl=%b st=0", ctl, st, NONE); end
  endtask
  task automatic test_load_use;
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rs ctl=%b exp=%b", ctl, STALL); end
    tick();
    checks++; if (ctl !== NONE) begin errors++; $display("FAIL lu_one_cycle ctl=%b exp=%b", ctl, NONE); end
    clear_in(); tick();
    ex_mem_read = 1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1; id_rs = 5'd9;
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rt ctl=%b exp=%b", ctl, STALL); end
    clear_in(); tick();
    ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    #1;
    checks++; if (ctl !== NONE) begin errors++; $display("FAIL lu_r0 ctl=%b exp=%b", ctl, NONE); end
    ex_rd = 5'd7; id_rs = 5'd7; id_uses_rs = 0; id_rt = 5'd7; id_uses_rt = 0;
    #1;
    checks++; if (ctl !== NONE) begin errors++; $display("FAIL lu_unused ctl=%b exp=%b", ctl, NONE); end
    ex_mem_read = 0; id_uses_rs = 1;
    #1;
    checks++; if (ctl !== NONE) begin errors++; $display("FAIL lu_noload ctl=%b exp=%b", ctl, NONE); end
    clear_in(); tick();
  endtask
  task automatic test_branch;
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1; br = 1;
    #1;
    checks++; if (ctl !== BRANCH || st !== 2'd0) begin errors++; $display("FAIL branch ctl=%b st=%0d exp ctl=%b st=0", ctl, st, BRANCH); end
    clear_in(); tick();
  endtask
  task automatic test_mem_wait;
    mem_req = 1; mem_ready = 0;
    #1;
    checks++; if (ctl !== MEMH || st !== 2'd0) begin errors++; $display("FAIL mem_entry ctl=%b st=%0d exp ctl=%b st=0", ctl, st, MEMH); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ctl !== MEMH || st !== 2'd1) begin errors++; $display("FAIL mem_wait%0d ctl=%b st=%0d exp ctl=%b st=1", i, ctl, st, MEMH); end
    end
    mem_ready = 1;
    #1;
    checks++; if (ctl !== NONE || st !== 2'd1) begin errors++; $display("FAIL mem_release ctl=%b st=%0d exp ctl=%b st=1", ctl, st, NONE); end
    tick(); clear_in();
    #1;
    checks++; if (ctl !== NONE || st !== 2'd0) begin errors++; $display("FAIL mem_run ctl=%b st=%0d exp ctl=%b st=0", ctl, st, NONE); end
  endtask
  task automatic test_md;
    md_start = 1;
    #1;
    checks++; if (ctl !== MDH || st !== 2'd0) begin errors++; $display("FAIL md_entry ctl=%b st=%0d exp ctl=%b st=0", ctl, st, MDH); end
    tick(); md_start = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== MDH || st !== 2'd2) begin errors++; $display("FAIL md_busy%0d ctl=%b st=%0d exp ctl=%b st=2", i, ctl, st, MDH); end
      tick();
    end
    checks++; if (ctl !== DONE || st !== 2'd0) begin errors++; $display("FAIL md_done ctl=%b st=%0d exp ctl=%b st=0", ctl, st, DONE); end
    tick();
    checks++; if (ctl !== NONE) begin errors++; $display("FAIL md_pulse ctl=%b exp=%b", ctl, NONE); end
  endtask
  task automatic test_md_freeze;
    md_start = 1;
    tick(); md_start = 0;
    tick(); cpu_en = 0;
    #1;
    checks++; if (ctl !== FRZ || st !== 2'd2) begin errors++; $display("FAIL frz1 ctl=%b st=%0d exp ctl=%b st=2", ctl, st, FRZ); end
    tick();
    checks++; if (ctl !== FRZ || st !== 2'd2) begin errors++; $display("FAIL frz2 ctl=%b st=%0d exp ctl=%b st=2", ctl, st, FRZ); end
    tick(); cpu_en = 1;
    #1;
    checks++; if (ctl !== MDH || st !== 2'd2) begin errors++; $display("FAIL frz_resume ctl=%b st=%0d exp ctl=%b st=2", ctl, st, MDH); end
    tick();
    checks++; if (ctl !== MDH || st !== 2'd2) begin errors++; $display("FAIL frz_last ctl=%b st=%0d exp ctl=%b st=2", ctl, st, MDH); end
    tick();
    checks++; if (ctl !== DONE || st !== 2'd0) begin errors++; $display("FAIL frz_done ctl=%b st=%0d exp ctl=%b st=0", ctl, st, DONE); end
    tick();
  endtask
  task automatic test_timeout;
    mem_req = 1; mem_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tout_early%0d got=%b exp=0", i, mem_timeout); end
      tick();
    end
    checks++; if (ctl !== (MEMH | TOUT) || st !== 2'd1) begin errors++; $display("FAIL tout_set ctl=%b st=%0d exp ctl=%b st=1", ctl, st, MEMH | TOUT); end
    mem_ready = 1;
    tick(); clear_in();
    #1;
    checks++; if (ctl !== TOUT || st !== 2'd0) begin errors++; $display("FAIL tout_sticky ctl=%b st=%0d exp ctl=%b st=0", ctl, st, TOUT); end
  endtask
  task automatic test_async_reset;
    md_start = 1;
    tick(); md_start = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++; if (ctl !== NONE || st !== 2'd0) begin errors++; $display("FAIL async_rst ctl=%b st=%0d exp ctl=%b st=0", ctl, st, NONE); end
    #3 rst_n = 1;
    tick();
    checks++; if (ctl !== NONE || st !== 2'd0) begin errors++; $display("FAIL async_post ctl=%b st=%0d exp ctl=%b st=0", ctl, st, NONE); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_md();
    test_md_freeze();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
